// File: rtl/dm_write_tracer_if.sv
// Bus bundle between the processor's data-memory write port / dump consumer and dm_write_tracer.
// master = the side that issues stores and consumes the dump stream; slave = the tracer.
interface dm_write_tracer_if #(
    parameter int N     = 64,
    parameter int DEPTH = 16
) ();
    logic                       DM_writeEnable;
    logic [N-1:0]               DM_addr;
    logic [N-1:0]               DM_writeData;
    logic                       dump;
    logic                       out_ready;
    logic                       out_valid;
    logic [N-1:0]               out_addr;
    logic [N-1:0]               out_data;
    logic [31:0]                out_stamp;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;
    logic                       dumping;
    logic                       done;

    modport master (
        output DM_writeEnable, DM_addr, DM_writeData, dump, out_ready,
        input  out_valid, out_addr, out_data, out_stamp, count, overflow, dumping, done
    );

    modport slave (
        input  DM_writeEnable, DM_addr, DM_writeData, dump, out_ready,
        output out_valid, out_addr, out_data, out_stamp, count, overflow, dumping, done
    );
endinterface

// File: rtl/dm_write_tracer.sv
// Captures qualifying data-memory stores {addr, data, cycle stamp} into a circular buffer
// and drains them oldest-first over a valid/ready stream on a rising edge of dump.
module dm_write_tracer #(
    parameter int           N         = 64,
    parameter int           DEPTH     = 16,
    parameter bit           MODE_WRAP = 1'b1,
    parameter logic [N-1:0] ADDR_LO   = '0,
    parameter logic [N-1:0] ADDR_HI   = '1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    dm_write_tracer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_CAPTURE, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [N-1:0] addr;
        logic [N-1:0] data;
        logic [31:0]  stamp;
    } entry_t;

    entry_t mem [DEPTH];

    state_t        state_reg, state_next;
    logic          dump_q_reg, dump_q_next;
    logic [31:0]   cycle_reg, cycle_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;

    logic   lo_ok, hi_ok, qualify, full, dump_rise, out_valid, pop, mem_we;
    entry_t rd_entry;

    // An open bound is folded away so the comparison never degenerates to a constant.
    generate
        if (ADDR_LO == '0) begin : g_lo_open
            assign lo_ok = 1'b1;
        end else begin : g_lo_cmp
            assign lo_ok = (bus.DM_addr >= ADDR_LO);
        end
        if (ADDR_HI == '1) begin : g_hi_open
            assign hi_ok = 1'b1;
        end else begin : g_hi_cmp
            assign hi_ok = (bus.DM_addr <= ADDR_HI);
        end
    endgenerate

    assign qualify   = bus.DM_writeEnable & lo_ok & hi_ok;
    assign full      = (count_reg == CW'(DEPTH));
    assign dump_rise = bus.dump & ~dump_q_reg;
    assign out_valid = (state_reg == S_DRAIN) && (count_reg != '0);
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        state_next    = state_reg;
        dump_q_next   = bus.dump;
        cycle_next    = cycle_reg + 32'd1;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        mem_we        = 1'b0;
        case (state_reg)
            S_CAPTURE: begin
                if (qualify) begin
                    if (!full) begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr_reg + PW'(1);
                        count_next  = count_reg + CW'(1);
                    end else if (MODE_WRAP) begin
                        // Full and wrapping: wr_ptr == rd_ptr, so the oldest slot is reused.
                        mem_we        = 1'b1;
                        wr_ptr_next   = wr_ptr_reg + PW'(1);
                        rd_ptr_next   = rd_ptr_reg + PW'(1);
                        overflow_next = 1'b1;
                    end else begin
                        overflow_next = 1'b1;
                    end
                end
                if (dump_rise) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (qualify) overflow_next = 1'b1;
                if (pop) begin
                    rd_ptr_next = rd_ptr_reg + PW'(1);
                    count_next  = count_reg - CW'(1);
                end
                if (count_next == '0) state_next = S_DONE;
            end
            S_DONE: begin
                if (!bus.dump) begin
                    state_next    = S_CAPTURE;
                    overflow_next = 1'b0;
                end
                // A store lost on the way back to capture is still recorded.
                if (qualify) overflow_next = 1'b1;
            end
            default: state_next = S_CAPTURE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_CAPTURE;
            dump_q_reg   <= 1'b0;
            cycle_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dump_q_reg   <= dump_q_next;
            cycle_reg    <= cycle_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Buffer storage carries no reset so it maps onto plain memory.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) mem[wr_ptr_reg] <= {bus.DM_addr, bus.DM_writeData, cycle_reg};
    end

    assign rd_entry      = mem[rd_ptr_reg];
    assign bus.out_valid = out_valid;
    assign bus.out_addr  = rd_entry.addr;
    assign bus.out_data  = rd_entry.data;
    assign bus.out_stamp = rd_entry.stamp;
    assign bus.count     = count_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.dumping   = (state_reg == S_DRAIN);
    assign bus.done      = (state_reg == S_DONE);
endmodule

// File: tb/tb_dm_write_tracer.sv
// Two tracers (wrap/full window and drop/0x100..0x1FF window) share one stimulus stream;
// each is compared every cycle against a queue-based model of the store/dump rules.
module tb_dm_write_tracer;
    localparam int N     = 64;
    localparam int DEPTH = 4;
    localparam int PH_CAP = 0, PH_DRN = 1, PH_DONE = 2;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [31:0] stamp;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_write_tracer_if #(.N(N), .DEPTH(DEPTH)) bus0 ();
    dm_write_tracer_if #(.N(N), .DEPTH(DEPTH)) bus1 ();

    dm_write_tracer #(.N(N), .DEPTH(DEPTH), .MODE_WRAP(1'b1),
                      .ADDR_LO(64'h0), .ADDR_HI(64'hFFFF_FFFF_FFFF_FFFF))
        dut0 (.CLOCK_50(clk), .reset(rst_n), .bus(bus0));

    dm_write_tracer #(.N(N), .DEPTH(DEPTH), .MODE_WRAP(1'b0),
                      .ADDR_LO(64'h100), .ADDR_HI(64'h1FF))
        dut1 (.CLOCK_50(clk), .reset(rst_n), .bus(bus1));

    // Reference model state
    ent_t        mq [2][$];
    int          ph [2];
    bit          m_ovf [2];
    bit          m_wrap [2];
    logic [63:0] m_lo [2];
    logic [63:0] m_hi [2];
    int unsigned cyc;
    bit          dump_prev;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input int i, input logic ov, input logic [63:0] oa, input logic [63:0] od,
                           input logic [31:0] os, input logic [2:0] cnt, input logic of,
                           input logic dg, input logic dn);
        bit exp_valid;
        exp_valid = (ph[i] == PH_DRN) && (mq[i].size() > 0);
        chk($sformatf("d%0d.out_valid", i), {63'd0, ov}, {63'd0, exp_valid});
        if (exp_valid) begin
            chk($sformatf("d%0d.out_addr", i), oa, mq[i][0].addr);
            chk($sformatf("d%0d.out_data", i), od, mq[i][0].data);
            chk($sformatf("d%0d.out_stamp", i), {32'd0, os}, {32'd0, mq[i][0].stamp});
        end
        chk($sformatf("d%0d.count", i), {61'd0, cnt}, 64'(mq[i].size()));
        chk($sformatf("d%0d.overflow", i), {63'd0, of}, {63'd0, m_ovf[i]});
        chk($sformatf("d%0d.dumping", i), {63'd0, dg}, {63'd0, ph[i] == PH_DRN});
        chk($sformatf("d%0d.done", i), {63'd0, dn}, {63'd0, ph[i] == PH_DONE});
    endtask

    task automatic check_all();
        chk_dut(0, bus0.out_valid, bus0.out_addr, bus0.out_data, bus0.out_stamp,
                bus0.count, bus0.overflow, bus0.dumping, bus0.done);
        chk_dut(1, bus1.out_valid, bus1.out_addr, bus1.out_data, bus1.out_stamp,
                bus1.count, bus1.overflow, bus1.dumping, bus1.done);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            ph[i] = PH_CAP;
            m_ovf[i] = 1'b0;
        end
        cyc = 0;
        dump_prev = 1'b0;
    endtask

    // Effect of one clock edge given the inputs presented before it.
    task automatic model_edge(input bit w, input logic [63:0] a, input logic [63:0] d,
                              input bit dm, input bit r);
        for (int i = 0; i < 2; i++) begin
            bit   qual;
            ent_t e;
            qual = w && (a >= m_lo[i]) && (a <= m_hi[i]);
            e.addr = a; e.data = d; e.stamp = cyc;
            case (ph[i])
                PH_CAP: begin
                    if (qual) begin
                        if (mq[i].size() < DEPTH) mq[i].push_back(e);
                        else if (m_wrap[i]) begin
                            void'(mq[i].pop_front());
                            mq[i].push_back(e);
                            m_ovf[i] = 1'b1;
                        end else m_ovf[i] = 1'b1;
                    end
                    if (dm && !dump_prev) ph[i] = PH_DRN;
                end
                PH_DRN: begin
                    if (qual) m_ovf[i] = 1'b1;
                    if (r && mq[i].size() > 0) void'(mq[i].pop_front());
                    if (mq[i].size() == 0) ph[i] = PH_DONE;
                end
                default: begin
                    if (!dm) begin
                        ph[i] = PH_CAP;
                        m_ovf[i] = 1'b0;
                    end
                    if (qual) m_ovf[i] = 1'b1;
                end
            endcase
        end
        dump_prev = dm;
        cyc++;
    endtask

    task automatic drive(input bit w, input logic [63:0] a, input logic [63:0] d,
                         input bit dm, input bit r);
        bus0.DM_writeEnable = w; bus0.DM_addr = a; bus0.DM_writeData = d;
        bus0.dump = dm; bus0.out_ready = r;
        bus1.DM_writeEnable = w; bus1.DM_addr = a; bus1.DM_writeData = d;
        bus1.dump = dm; bus1.out_ready = r;
    endtask

    // One cycle: inputs set at negedge, edge, compare at next negedge.
    task automatic step(input bit w, input logic [63:0] a, input logic [63:0] d,
                        input bit dm, input bit r);
        drive(w, a, d, dm, r);
        model_edge(w, a, d, dm, r);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d);
        step(1'b1, a, d, 1'b0, 1'b1);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // rmode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
    // store_step: drain step carrying a store at 0x150 (0 = same edge as the dump rise).
    task automatic drain(input int rmode, input int store_step);
        int  k;
        bit  r;
        k = 0;
        while (!(ph[0] == PH_DONE && ph[1] == PH_DONE) && k < 60) begin
            case (rmode)
                0: r = 1'b1;
                1: r = (k % 4 == 0) || (k % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            step(k == store_step, 64'h150, rnd64(), 1'b1, r);
            k++;
        end
        chk("drain_bound", {63'd0, (bus0.done & bus1.done)}, 64'd1);
        step(1'b0, 64'h0, 64'h0, 1'b1, 1'b1);   // level dump held: no restart
        step(1'b0, 64'h0, 64'h0, 1'b1, 1'b1);
        step(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);   // release returns to capture
    endtask

    initial begin
        m_wrap[0] = 1'b1; m_lo[0] = 64'h0;   m_hi[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        m_wrap[1] = 1'b0; m_lo[1] = 64'h100; m_hi[1] = 64'h1FF;
        model_reset();
        drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Basic capture: stores at cycles 3 and 5, stamps 3 and 5
        for (int c = 0; c < 7; c++) begin
            if (c == 3)      store(64'h08, 64'hA);
            else if (c == 5) store(64'h10, 64'hB);
            else             step(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
        end
        drain(0, -1);

        // Wrap vs drop: six stores, data 1..6
        for (int i = 0; i < 6; i++) store(64'h100 + 64'(8 * i), 64'(i + 1));
        drain(0, -1);

        // Address filter with backpressure
        store(64'h0FF, rnd64());
        store(64'h100, rnd64());
        store(64'h1FF, rnd64());
        store(64'h200, rnd64());
        drain(1, -1);

        // Store coincident with the dump edge
        store(64'h140, rnd64());
        drain(0, 0);
        // Store during DRAIN
        store(64'h160, rnd64());
        store(64'h170, rnd64());
        store(64'h180, rnd64());
        drain(0, 2);
        // Empty dump
        drain(0, -1);

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(2, 10);
            for (int j = 0; j < n; j++)
                step(($urandom_range(0, 9) < 7), 64'($urandom_range(32'hF0, 32'h210)), rnd64(),
                     1'b0, 1'($urandom_range(0, 1)));
            drain(2, int'($urandom_range(0, 4)) - 1);
        end

        // Reset mid-drain
        for (int i = 0; i < 5; i++) store(64'h110 + 64'(i), rnd64());
        step(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        store(64'h1A0, rnd64());        // stamp restarts at 0
        store(64'h1A8, rnd64());
        drain(0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
